// File: rtl/seq_stim_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_stim_gen_pkg
// Shared definitions for the sequenced stimulus generator:
//   - state_t : controller states (2-bit encoding, IDLE/RUN/DONE)
//   - HOLD_CW : width of the hold-interval counter
// -----------------------------------------------------------------------------
package seq_stim_gen_pkg;

  localparam int HOLD_CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : seq_stim_gen_pkg

// File: rtl/seq_stim_gen_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Counts the clock cycles a sequence value has been held.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset (count -> 0)
//   clear  in  synchronous clear (count -> 0), wins over enable
//   enable in  advance the count this edge
//   expire out combinational: enable high and count == HOLD-1
// The count wraps to 0 on the expiry edge so the next interval starts
// without needing a separate clear.
// -----------------------------------------------------------------------------
module hold_timer
  import seq_stim_gen_pkg::*;
#(
  parameter int unsigned HOLD = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [HOLD_CW-1:0] LAST = HOLD_CW'(HOLD - 1);

  logic [HOLD_CW-1:0] r_count;
  logic               w_at_last;

  assign w_at_last = (r_count == LAST);
  assign expire    = enable && w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule : hold_timer

// File: rtl/seq_stim_gen.sv
// -----------------------------------------------------------------------------
// seq_stim_gen
// Clocked stimulus source for a combinational downstream block. Drives an
// ascending sequence START_VAL..END_VAL on seq_out, holding each value for
// HOLD cycles, and samples the block's response (dut_in) at the end of each
// hold interval.
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   level; begins a sequence from IDLE or DONE
//   pause      in   level; freezes the hold timer while running
//   dut_in     in   response of the downstream block
//   seq_out    out  value driven to the downstream block
//   seq_valid  out  seq_out carries a sequence value
//   samp_out   out  last sampled response
//   samp_valid out  one-cycle strobe when samp_out updates
//   busy       out  sequence running
//   done       out  sequence complete; last value still driven
//   dbg_state  out  current controller state
//
// Valid semantics: seq_valid and samp_valid are qualifiers without a ready
// side. The consumer cannot stall the generator; samp_valid is a single-cycle
// strobe and samp_out is stable until the next strobe.
// -----------------------------------------------------------------------------
module seq_stim_gen
  import seq_stim_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HOLD      = 50,
  parameter int unsigned START_VAL = 1,
  parameter int unsigned END_VAL   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] dut_in,
  output logic [WIDTH-1:0] seq_out,
  output logic             seq_valid,
  output logic [WIDTH-1:0] samp_out,
  output logic             samp_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Parameter sanity: a descending range would wrap the value register.
  if (END_VAL < START_VAL) begin : g_bad_range
    $error("seq_stim_gen: END_VAL must be >= START_VAL");
  end
  if ((HOLD < 1) || (HOLD > 65535)) begin : g_bad_hold
    $error("seq_stim_gen: HOLD must be in 1..65535");
  end

  localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VAL);
  localparam logic [WIDTH-1:0] END_W   = WIDTH'(END_VAL);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_seq_out;
  logic [WIDTH-1:0] w_seq_nxt;
  logic             r_seq_valid;
  logic             w_seq_valid_nxt;
  logic [WIDTH-1:0] r_samp_out;
  logic [WIDTH-1:0] w_samp_nxt;
  logic             r_samp_valid;
  logic             w_samp_valid_nxt;
  logic             w_clear;
  logic             w_enable;
  logic             w_expire;

  // Timer only advances in RUN with pause low, so pause also masks expiry.
  assign w_enable = (r_state == ST_RUN) && !pause;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_enable),
    .expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_seq_out    <= '0;
      r_seq_valid  <= 1'b0;
      r_samp_out   <= '0;
      r_samp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_seq_out    <= w_seq_nxt;
      r_seq_valid  <= w_seq_valid_nxt;
      r_samp_out   <= w_samp_nxt;
      r_samp_valid <= w_samp_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_seq_nxt        = r_seq_out;
    w_seq_valid_nxt  = r_seq_valid;
    w_samp_nxt       = r_samp_out;
    w_samp_valid_nxt = 1'b0;
    w_clear          = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt     = ST_RUN;
          w_seq_nxt       = START_W;
          w_seq_valid_nxt = 1'b1;
          w_clear         = 1'b1;
        end
      end

      ST_RUN: begin
        // start is deliberately ignored here; only expiry moves the sequence.
        if (w_expire) begin
          w_samp_nxt       = dut_in;
          w_samp_valid_nxt = 1'b1;
          if (r_seq_out == END_W) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_seq_nxt = r_seq_out + WIDTH'(1);
          end
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_seq_nxt       = '0;
        w_seq_valid_nxt = 1'b0;
      end
    endcase
  end

  assign seq_out    = r_seq_out;
  assign seq_valid  = r_seq_valid;
  assign samp_out   = r_samp_out;
  assign samp_valid = r_samp_valid;
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign dbg_state  = r_state;

endmodule : seq_stim_gen

// File: tb/tb_seq_stim_gen.sv
module tb_seq_stim_gen;

  // ---------------------------------------------------------------- clock/reset
  logic clk    = 1'b0;
  bit   clk_en = 1'b1;
  logic rst    = 1'b0;
  logic rst_a  = 1'b0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // ------------------------------------------------------------ DUT A: defaults
  logic       start_a = 1'b0, pause_a = 1'b0;
  logic [7:0] dut_in_a, seq_out_a, samp_out_a;
  logic       seq_valid_a, samp_valid_a, busy_a, done_a;
  logic [1:0] dbg_state_a;
  assign dut_in_a = ~seq_out_a;

  seq_stim_gen u_dut_a (
    .clk(clk), .rst(rst || rst_a), .start(start_a), .pause(pause_a),
    .dut_in(dut_in_a), .seq_out(seq_out_a), .seq_valid(seq_valid_a),
    .samp_out(samp_out_a), .samp_valid(samp_valid_a), .busy(busy_a),
    .done(done_a), .dbg_state(dbg_state_a)
  );

  // ------------------------------------- DUT B: HOLD=1, single value 0xFF
  logic       start_b = 1'b0, pause_b = 1'b0;
  logic [7:0] dut_in_b, seq_out_b, samp_out_b;
  logic       seq_valid_b, samp_valid_b, busy_b, done_b;
  logic [1:0] dbg_state_b;
  assign dut_in_b = seq_out_b ^ 8'h5A;

  seq_stim_gen #(.WIDTH(8), .HOLD(1), .START_VAL(255), .END_VAL(255)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause_b),
    .dut_in(dut_in_b), .seq_out(seq_out_b), .seq_valid(seq_valid_b),
    .samp_out(samp_out_b), .samp_valid(samp_valid_b), .busy(busy_b),
    .done(done_b), .dbg_state(dbg_state_b)
  );

  // ------------------------------------------- DUT D: HOLD=1, values 10..13
  logic       start_d = 1'b0, pause_d = 1'b0;
  logic [7:0] dut_in_d, seq_out_d, samp_out_d;
  logic       seq_valid_d, samp_valid_d, busy_d, done_d;
  logic [1:0] dbg_state_d;
  assign dut_in_d = seq_out_d + 8'd1;

  seq_stim_gen #(.WIDTH(8), .HOLD(1), .START_VAL(10), .END_VAL(13)) u_dut_d (
    .clk(clk), .rst(rst), .start(start_d), .pause(pause_d),
    .dut_in(dut_in_d), .seq_out(seq_out_d), .seq_valid(seq_valid_d),
    .samp_out(samp_out_d), .samp_valid(samp_valid_d), .busy(busy_d),
    .done(done_d), .dbg_state(dbg_state_d)
  );

  // -------------------------------- DUT C: HOLD=3, values 2..6, random drive
  localparam int HOLD_C = 3;
  localparam int START_C = 2;
  localparam int END_C = 6;
  localparam int N_C = END_C - START_C + 1;
  logic       start_c = 1'b0, pause_c = 1'b0;
  logic [7:0] dut_in_c, seq_out_c, samp_out_c;
  logic       seq_valid_c, samp_valid_c, busy_c, done_c;
  logic [1:0] dbg_state_c;
  assign dut_in_c = 8'(seq_out_c * 8'd3 + 8'd1);

  seq_stim_gen #(.WIDTH(8), .HOLD(HOLD_C), .START_VAL(START_C), .END_VAL(END_C)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .pause(pause_c),
    .dut_in(dut_in_c), .seq_out(seq_out_c), .seq_valid(seq_valid_c),
    .samp_out(samp_out_c), .samp_valid(samp_valid_c), .busy(busy_c),
    .done(done_c), .dbg_state(dbg_state_c)
  );

  // ------------------------------------------------------------- scoreboard
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_c[$];
  int a_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle of DUT A with the sample stream checked against exp_q_a.
  task automatic a_cycle();
    logic [7:0] e;
    step();
    if (samp_valid_a) begin
      a_cnt++;
      e = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 8'hxx;
      chk("a samp_out", {24'd0, samp_out_a}, {24'd0, e});
    end
  endtask

  task automatic push_a(input int first, input int last);
    for (int v = first; v <= last; v++) exp_q_a.push_back(~8'(v));
  endtask

  // -------------------------------------------------------- vector table
  typedef struct {
    logic       start;
    logic       pause;
    int         cycles;
    logic [7:0] exp_seq;
    logic       exp_sv;
    logic       exp_busy;
    logic       exp_done;
    int         exp_samps;
  } vec_t;

  vec_t vecs[17];

  // ---------------------------------------------------- reference model (C)
  int         m_mode;   // 0 idle, 1 running, 2 finished
  int         m_active; // unpaused running cycles since the last start
  logic       m_sv;
  logic [7:0] m_last;

  function automatic logic [7:0] f_c(input int v);
    return 8'((v * 3 + 1) & 255);
  endfunction

  task automatic model_c_edge(input logic st, input logic pa);
    m_sv = 1'b0;
    if (m_mode != 1) begin
      if (st) begin
        m_mode   = 1;
        m_active = 0;
      end
    end else if (!pa) begin
      m_active++;
      if (m_active % HOLD_C == 0) begin
        m_sv   = 1'b1;
        m_last = f_c(START_C + m_active / HOLD_C - 1);
        exp_q_c.push_back(m_last);
        if (m_active == HOLD_C * N_C) m_mode = 2;
      end
    end
  endtask

  function automatic int model_c_seq();
    if (m_mode == 0) return 0;
    if (m_mode == 2) return END_C;
    return START_C + m_active / HOLD_C;
  endfunction

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ------------------------------------------------------------------- test
  initial begin
    logic [7:0] e;

    //            st    pa    cyc  seq    sv    busy  done  samps
    vecs[0]  = '{1'b1, 1'b0,   1, 8'd1, 1'b1, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0,  49, 8'd1, 1'b1, 1'b1, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0,   1, 8'd2, 1'b1, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b0, 1'b0,  60, 8'd3, 1'b1, 1'b1, 1'b0, 1};
    vecs[4]  = '{1'b0, 1'b1,  10, 8'd3, 1'b1, 1'b1, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b0,  39, 8'd3, 1'b1, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b0,   1, 8'd4, 1'b1, 1'b1, 1'b0, 1};
    vecs[7]  = '{1'b0, 1'b0,  49, 8'd4, 1'b1, 1'b1, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b1,   5, 8'd4, 1'b1, 1'b1, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b0,   1, 8'd5, 1'b1, 1'b1, 1'b0, 1};
    vecs[10] = '{1'b1, 1'b0, 100, 8'd7, 1'b1, 1'b1, 1'b0, 2};
    vecs[11] = '{1'b0, 1'b0,  99, 8'd8, 1'b1, 1'b1, 1'b0, 1};
    vecs[12] = '{1'b0, 1'b0,   1, 8'd8, 1'b1, 1'b0, 1'b1, 1};
    vecs[13] = '{1'b0, 1'b0,  20, 8'd8, 1'b1, 1'b0, 1'b1, 0};
    vecs[14] = '{1'b1, 1'b0,   1, 8'd1, 1'b1, 1'b1, 1'b0, 0};
    vecs[15] = '{1'b0, 1'b0, 399, 8'd8, 1'b1, 1'b1, 1'b0, 7};
    vecs[16] = '{1'b0, 1'b0,   1, 8'd8, 1'b1, 1'b0, 1'b1, 1};

    // Reset across two rising edges, then release.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst seq_out",    {24'd0, seq_out_a}, 32'd0);
    chk("rst seq_valid",  {31'd0, seq_valid_a}, 32'd0);
    chk("rst samp_out",   {24'd0, samp_out_a}, 32'd0);
    chk("rst samp_valid", {31'd0, samp_valid_a}, 32'd0);
    chk("rst busy",       {31'd0, busy_a}, 32'd0);
    chk("rst done",       {31'd0, done_a}, 32'd0);
    chk("rst state",      {30'd0, dbg_state_a}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle busy", {31'd0, busy_a}, 32'd0);
    chk("idle pause no effect seq", {24'd0, seq_out_a}, 32'd0);

    // Table-driven run of DUT A: two full sequences with pauses and restart.
    push_a(1, 8);
    push_a(1, 8);
    for (int i = 0; i < 17; i++) begin
      start_a = vecs[i].start;
      pause_a = vecs[i].pause;
      a_cnt   = 0;
      for (int c = 0; c < vecs[i].cycles; c++) a_cycle();
      chk($sformatf("vec%0d seq_out", i),    {24'd0, seq_out_a},   {24'd0, vecs[i].exp_seq});
      chk($sformatf("vec%0d seq_valid", i),  {31'd0, seq_valid_a}, {31'd0, vecs[i].exp_sv});
      chk($sformatf("vec%0d busy", i),       {31'd0, busy_a},      {31'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d done", i),       {31'd0, done_a},      {31'd0, vecs[i].exp_done});
      chk($sformatf("vec%0d samp count", i), a_cnt,                vecs[i].exp_samps);
    end
    start_a = 1'b0;
    pause_a = 1'b0;
    chk("done keeps samp_out", {24'd0, samp_out_a}, 32'hF7);

    // Restart, run to value 5, then async reset with the clock stopped.
    push_a(1, 4);
    start_a = 1'b1;
    a_cycle();
    start_a = 1'b0;
    for (int c = 0; c < 210; c++) a_cycle();
    chk("pre-rst seq_out", {24'd0, seq_out_a}, 32'd5);
    clk_en = 1'b0;
    #2;
    rst_a = 1'b1;
    #1;
    chk("async rst clk low",    {31'd0, clk}, 32'd0);
    chk("async rst seq_out",    {24'd0, seq_out_a}, 32'd0);
    chk("async rst seq_valid",  {31'd0, seq_valid_a}, 32'd0);
    chk("async rst samp_out",   {24'd0, samp_out_a}, 32'd0);
    chk("async rst samp_valid", {31'd0, samp_valid_a}, 32'd0);
    chk("async rst busy",       {31'd0, busy_a}, 32'd0);
    chk("async rst state",      {30'd0, dbg_state_a}, 32'd0);
    #1;
    rst_a = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    a_cnt = 0;
    for (int c = 0; c < 60; c++) a_cycle();
    chk("post-rst no samples", a_cnt, 0);
    chk("post-rst seq_out", {24'd0, seq_out_a}, 32'd0);
    push_a(1, 1);
    start_a = 1'b1;
    a_cycle();
    start_a = 1'b0;
    chk("post-rst start seq", {24'd0, seq_out_a}, 32'd1);
    for (int c = 0; c < 50; c++) a_cycle();
    chk("post-rst 2nd value", {24'd0, seq_out_a}, 32'd2);
    chk("a expected queue drained", exp_q_a.size(), 0);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;

    // DUT B: HOLD=1 and a single value.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b seq_out k",    {24'd0, seq_out_b}, 32'hFF);
    chk("b busy k",       {31'd0, busy_b}, 32'd1);
    chk("b samp_valid k", {31'd0, samp_valid_b}, 32'd0);
    step();
    chk("b samp_valid k1", {31'd0, samp_valid_b}, 32'd1);
    chk("b samp_out k1",   {24'd0, samp_out_b}, 32'hA5);
    chk("b done k1",       {31'd0, done_b}, 32'd1);
    chk("b busy k1",       {31'd0, busy_b}, 32'd0);
    step();
    chk("b samp_valid k2", {31'd0, samp_valid_b}, 32'd0);
    chk("b done k2",       {31'd0, done_b}, 32'd1);
    chk("b seq_out k2",    {24'd0, seq_out_b}, 32'hFF);
    chk("b seq_valid k2",  {31'd0, seq_valid_b}, 32'd1);

    // DUT D: HOLD=1 gives back-to-back sample strobes.
    start_d = 1'b1;
    step();
    start_d = 1'b0;
    chk("d seq_out k", {24'd0, seq_out_d}, 32'd10);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("d%0d samp_valid", i), {31'd0, samp_valid_d}, 32'd1);
      chk($sformatf("d%0d samp_out", i),   {24'd0, samp_out_d}, 32'(10 + i));
      chk($sformatf("d%0d seq_out", i),    {24'd0, seq_out_d}, (i < 4) ? 32'(10 + i) : 32'd13);
      chk($sformatf("d%0d done", i),       {31'd0, done_d}, (i == 4) ? 32'd1 : 32'd0);
    end
    step();
    chk("d samp_valid end", {31'd0, samp_valid_d}, 32'd0);
    chk("d done end",       {31'd0, done_d}, 32'd1);

    // DUT C: random start/pause against the reference model.
    m_mode = 0; m_active = 0; m_sv = 1'b0; m_last = 8'd0;
    for (int n = 0; n < 800; n++) begin
      start_c = ($urandom_range(0, 7) == 0);
      pause_c = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_c_edge(start_c, pause_c);
      @(negedge clk);
      chk("c seq_out",    {24'd0, seq_out_c},   32'(model_c_seq()));
      chk("c seq_valid",  {31'd0, seq_valid_c}, (m_mode != 0) ? 32'd1 : 32'd0);
      chk("c busy",       {31'd0, busy_c},      (m_mode == 1) ? 32'd1 : 32'd0);
      chk("c done",       {31'd0, done_c},      (m_mode == 2) ? 32'd1 : 32'd0);
      chk("c samp_valid", {31'd0, samp_valid_c}, {31'd0, m_sv});
      if (samp_valid_c) begin
        e = (exp_q_c.size() > 0) ? exp_q_c.pop_front() : 8'hxx;
        chk("c samp_out strobe", {24'd0, samp_out_c}, {24'd0, e});
      end else begin
        chk("c samp_out held", {24'd0, samp_out_c}, {24'd0, m_last});
      end
    end
    start_c = 1'b0;
    pause_c = 1'b0;
    chk("c expected queue drained", exp_q_c.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_stim_gen

// File: doc/seq_stim_gen.md
Name: seq_stim_gen

Overview:
- Upstream stimulus stage for the 8-bit combinational `model` block: drives its `in1` with an ascending value sequence, holding each value for a fixed number of clock cycles.
- Samples the block's `out1` response at the end of each hold interval and presents it with a one-cycle valid strobe.
- Replaces hand-written delay sequences with a clocked, restartable source that is usable in silicon and in benches.

Parameters:
- WIDTH, 8: data width of the driven value and the sampled response.
- HOLD, 50: clock cycles each value is held. Legal range 1..65535.
- START_VAL, 1: first value driven.
- END_VAL, 8: last value driven. Must satisfy END_VAL >= START_VAL; violation is an elaboration-time error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each edge; begins a sequence when in IDLE or DONE.
- pause  in  1  level; freezes the hold timer while in RUN.
- dut_in  in  WIDTH  response from the downstream block (`out1`).
- seq_out  out  WIDTH  value driven to the downstream block (`in1`).
- seq_valid  out  1  high while seq_out carries a sequence value.
- samp_out  out  WIDTH  last sampled response.
- samp_valid  out  1  one-cycle strobe when samp_out updates.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset: rst high forces the following immediately, regardless of clk:
  - state = IDLE.
  - seq_out = 0, seq_valid = 0, samp_out = 0, samp_valid = 0, busy = 0, done = 0.
  - hold counter = 0.
  - Reset asserted mid-RUN abandons the sequence; no sample is produced.
- States: IDLE, RUN, DONE; encoding is 2 bits.
- IDLE/DONE with start = 1 at edge k, the following take effect after edge k:
  - state becomes RUN.
  - seq_out = START_VAL, seq_valid = 1, busy = 1, done = 0.
  - hold counter = 0.
- RUN, each edge:
  - pause = 1: counter, seq_out and state all hold; samp_valid = 0.
  - pause = 0 and counter < HOLD-1: counter increments.
  - pause = 0 and counter == HOLD-1 (expiry): samp_out <= dut_in, samp_valid = 1 for exactly one cycle, counter <= 0. Then:
    - if seq_out != END_VAL: seq_out <= seq_out + 1.
    - if seq_out == END_VAL: state <= DONE, busy = 0, done = 1.
- Timing without pause: each value is visible for exactly HOLD cycles. The first sample strobe follows edge k+HOLD.
- Total RUN length is HOLD*(END_VAL-START_VAL+1) cycles plus the number of paused cycles.
- start while in RUN is ignored.
- pause while in IDLE or DONE has no effect.
- pause and expiry in the same cycle: pause wins, and expiry occurs on the first unpaused edge.
- DONE:
  - seq_out keeps END_VAL and seq_valid stays 1; the last value persists to the downstream block.
  - samp_out keeps its last sample.
  - done stays high until a new start or rst.
- start in DONE restarts exactly as from IDLE. done falls after the same edge at which seq_out reloads START_VAL.
- HOLD = 1: a new value every cycle, and samp_valid is high on consecutive cycles.
- START_VAL == END_VAL: a single value, one sample, then DONE.
- Arithmetic:
  - seq_out increments are WIDTH-bit unsigned. No wrap is possible because of the END_VAL >= START_VAL check.
  - The hold counter is 16 bits unsigned and compared against HOLD-1.
- dut_in is sampled synchronously. The downstream block is combinational and must settle within one cycle.

Decomposition:
- Shared include file of localparams:
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - HOLD_CW = 16, the hold counter width.
- One sub-module: `hold_timer`.
  - Ports: clk, rst, clear, enable, HOLD parameter, expire output.
  - Behaviour: 16-bit counter with synchronous clear, and expire asserted combinationally when count == HOLD-1 and enable is high.
  - The top level keeps the FSM, the value register and the sample register.

Test Plan:
- Reset at t=0, then release → all outputs 0 and state IDLE. A further rst pulse is applied mid-cycle with clk stopped, and outputs clear without a clock edge.
- Defaults, with dut_in = ~seq_out loopback, start pulsed one cycle:
  - seq_out steps 1..8, each value held 50 cycles.
  - 8 samp_valid pulses spaced 50 cycles, with samp_out = 0xFE, 0xFD, …, 0xF7.
  - busy for 400 cycles, then done = 1 and seq_out stays 8.
- pause high for 10 cycles while seq_out = 3:
  - value 3 is visible for 60 cycles.
  - no samp_valid during the pause.
  - done arrives at cycle 410.
  - pause raised exactly on the expiry cycle delays the expiry by the pause length.
- start held high during RUN → no restart and sequence unchanged. start in DONE → seq_out = 1 and done = 0 after the same edge; the full sequence repeats.
- rst asserted while seq_out = 5:
  - immediate return to IDLE, all outputs 0, no sample strobe.
  - a subsequent start begins at 1.
- HOLD = 1, START_VAL = END_VAL = 0xFF:
  - seq_out = 0xFF for one cycle, a single samp_valid, then DONE.
  - done is high one edge after the sample and seq_out remains 0xFF.
